// File: rtl/cpu_pkg.sv
// Shared core definitions: default register-file geometry and the hard-wired zero register index.
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 2;
    localparam int REG_ZERO   = 0;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_sb_cnt.sv
// One pending-producer counter for a single architectural register.
// An issue and a retire in the same cycle cancel; a retire against zero raises underflow.
module regfile_sb_cnt
    import cpu_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             full,
    output logic             underflow
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign zero      = (cnt_q == '0);
    assign full      = (cnt_q == '1);
    assign underflow = dec && zero;
    assign count     = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with write-back bypass and a per-register pending-write
// scoreboard that reports read hazards to decode.
module regfile_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_stall,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     wb_clr,
    output logic                     sb_err
);

    localparam int                NREG     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              sb_err_q;
    logic              sb_err_d;

    logic [CNT_W-1:0]  cnt [NREG];
    logic [NREG-1:0]   cnt_zero;
    logic [NREG-1:0]   cnt_full;
    logic [NREG-1:0]   cnt_unf;
    logic              issue_fire;
    logic              retire;

    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != ZERO_IDX)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // The zero register is never tracked, so it behaves as an always-empty, never-full counter.
    assign cnt[0]      = '0;
    assign cnt_zero[0] = 1'b1;
    assign cnt_full[0] = 1'b0;
    assign cnt_unf[0]  = 1'b0;

    assign iss_ready  = (iss_addr == ZERO_IDX) || !cnt_full[iss_addr];
    assign issue_fire = iss_valid && iss_ready;
    assign retire     = wb_en && wb_clr && (wb_addr != ZERO_IDX);

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);

        regfile_sb_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (issue_fire && (iss_addr == IDX)),
            .dec      (retire && (wb_addr == IDX)),
            .count    (cnt[g]),
            .zero     (cnt_zero[g]),
            .full     (cnt_full[g]),
            .underflow(cnt_unf[g])
        );
    end

    always_comb begin
        sb_err_d = sb_err_q || (|cnt_unf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    // A retire of the last producer this cycle delivers its data via the bypass, so no stall.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              bypass;
        logic              resolves;

        assign addr     = rd_addr[i*ADDR_W +: ADDR_W];
        assign bypass   = wb_en && (wb_addr == addr);
        assign resolves = bypass && wb_clr && (cnt[addr] == CNT_W'(1));

        assign rd_data[i*DATA_W +: DATA_W] = (addr == ZERO_IDX) ? '0 :
                                             bypass             ? wb_data :
                                                                  regs_q[addr];
        assign rd_stall[i] = (addr != ZERO_IDX) && !cnt_zero[addr] && !resolves;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_stall;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_clr;
    logic        sb_err;

    int checks;
    int errors;

    logic [31:0] mRegs [32];
    int          mCnt  [32];
    bit          mErr;
    bit          mReady;

    regfile_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_stall (rd_stall),
        .iss_valid(iss_valid),
        .iss_addr (iss_addr),
        .iss_ready(iss_ready),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_clr   (wb_clr),
        .sb_err   (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] expData(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mRegs[a];
    endfunction

    function automatic bit expStall(input logic [4:0] a);
        bit finalRetire;
        finalRetire = wb_en && wb_clr && wb_addr == a && mCnt[a] == 1;
        return (a != 5'd0) && (mCnt[a] > 0) && !finalRetire;
    endfunction

    // Drive one cycle's inputs, then compare every output against the model mid-cycle.
    task automatic applyStimulus(input bit r, input logic [4:0] ra0, input logic [4:0] ra1,
                                 input bit iv, input logic [4:0] ia,
                                 input bit we, input logic [4:0] wa, input logic [31:0] wd,
                                 input bit wc);
        rst = r; rd_addr = {ra1, ra0};
        iss_valid = iv; iss_addr = ia;
        wb_en = we; wb_addr = wa; wb_data = wd; wb_clr = wc;
        #4;
        mReady = (ia == 5'd0) || (mCnt[ia] != 3);
        checkOutput("rd_data0", rd_data[31:0], expData(ra0));
        checkOutput("rd_data1", rd_data[63:32], expData(ra1));
        checkOutput("rd_stall0", 32'(rd_stall[0]), 32'(expStall(ra0)));
        checkOutput("rd_stall1", 32'(rd_stall[1]), 32'(expStall(ra1)));
        checkOutput("iss_ready", 32'(iss_ready), 32'(mReady));
        checkOutput("sb_err", 32'(sb_err), 32'(mErr));
    endtask

    // Advance the model by the rules of one clock edge, then the clock itself.
    task automatic stepClock();
        bit fire;
        bit ret;
        int pre;
        fire = iss_valid && mReady && iss_addr != 5'd0;
        ret  = wb_en && wb_clr && wb_addr != 5'd0;
        if (rst) begin
            for (int k = 0; k < 32; k++) begin
                mRegs[k] = 32'd0;
                mCnt[k]  = 0;
            end
            mErr = 1'b0;
        end else begin
            if (wb_en && wb_addr != 5'd0) mRegs[wb_addr] = wb_data;
            pre = mCnt[wb_addr];
            if (ret && pre == 0) mErr = 1'b1;
            if (fire && ret && iss_addr == wb_addr) begin
                // issue and retire cancel
            end else begin
                if (fire) mCnt[iss_addr]++;
                if (ret && pre > 0) mCnt[wb_addr]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        applyStimulus(0, ra0, ra1, 0, 5'd0, 0, 5'd0, 32'd0, 0);
    endtask

    initial begin
        bit          holdIss;
        bit          iv;
        logic [4:0]  ia;
        checks = 0;
        errors = 0;
        mErr   = 1'b0;
        for (int k = 0; k < 32; k++) begin
            mRegs[k] = 32'hX;
            mCnt[k]  = 0;
        end
        @(posedge clk);
        #1;

        // Reset overrides a concurrent write.
        applyStimulus(1, 5'd3, 5'd3, 0, 5'd0, 1, 5'd3, 32'hDEADBEEF, 0); stepClock();
        applyStimulus(1, 5'd3, 5'd3, 0, 5'd0, 1, 5'd3, 32'hDEADBEEF, 0); stepClock();
        idle(5'd3, 5'd0);
        checkOutput("reset_reg3", rd_data[31:0], 32'd0);
        checkOutput("reset_err", 32'(sb_err), 32'd0);
        stepClock();

        applyStimulus(0, 5'd0, 5'd0, 0, 5'd0, 1, 5'd0, 32'h1234, 0); stepClock();
        idle(5'd0, 5'd0);
        checkOutput("zero_reg", rd_data[31:0], 32'd0);
        stepClock();

        applyStimulus(0, 5'd7, 5'd7, 0, 5'd0, 1, 5'd7, 32'hA5A5A5A5, 0);
        checkOutput("bypass_p0", rd_data[31:0], 32'hA5A5A5A5);
        checkOutput("bypass_p1", rd_data[63:32], 32'hA5A5A5A5);
        stepClock();
        idle(5'd7, 5'd7);
        checkOutput("written_p0", rd_data[31:0], 32'hA5A5A5A5);
        checkOutput("written_p1", rd_data[63:32], 32'hA5A5A5A5);
        stepClock();

        applyStimulus(0, 5'd0, 5'd0, 1, 5'd5, 0, 5'd0, 32'd0, 0); stepClock();
        idle(5'd5, 5'd5);
        checkOutput("sb_stall", 32'(rd_stall[0]), 32'd1);
        stepClock();
        applyStimulus(0, 5'd5, 5'd5, 0, 5'd0, 1, 5'd5, 32'h42, 1);
        checkOutput("resolve_stall", 32'(rd_stall[0]), 32'd0);
        checkOutput("resolve_data", rd_data[31:0], 32'h42);
        stepClock();
        idle(5'd5, 5'd5);
        checkOutput("after_stall", 32'(rd_stall[1]), 32'd0);
        checkOutput("after_data", rd_data[63:32], 32'h42);
        stepClock();

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 5'd9, 5'd9, 1, 5'd9, 0, 5'd0, 32'd0, 0); stepClock();
        end
        applyStimulus(0, 5'd9, 5'd9, 1, 5'd9, 0, 5'd0, 32'd0, 0);
        checkOutput("sat_ready", 32'(iss_ready), 32'd0);
        stepClock();
        applyStimulus(0, 5'd9, 5'd9, 0, 5'd9, 1, 5'd9, 32'h1, 1); stepClock();
        idle(5'd9, 5'd9);
        applyStimulus(0, 5'd9, 5'd9, 0, 5'd9, 0, 5'd0, 32'd0, 0);
        checkOutput("unsat_ready", 32'(iss_ready), 32'd1);
        stepClock();
        applyStimulus(0, 5'd9, 5'd9, 0, 5'd0, 1, 5'd9, 32'h2, 1); stepClock();
        idle(5'd9, 5'd9);
        checkOutput("sat_stall_hold", 32'(rd_stall[0]), 32'd1);
        stepClock();
        applyStimulus(0, 5'd9, 5'd9, 0, 5'd0, 1, 5'd9, 32'h3, 1);
        checkOutput("sat_last_retire", 32'(rd_stall[0]), 32'd0);
        stepClock();

        applyStimulus(0, 5'd4, 5'd4, 1, 5'd4, 0, 5'd0, 32'd0, 0); stepClock();
        applyStimulus(0, 5'd4, 5'd4, 1, 5'd4, 1, 5'd4, 32'h77, 1); stepClock();
        idle(5'd4, 5'd4);
        checkOutput("cancel_stall", 32'(rd_stall[0]), 32'd1);
        checkOutput("cancel_data", rd_data[31:0], 32'h77);
        stepClock();
        applyStimulus(0, 5'd4, 5'd4, 0, 5'd0, 1, 5'd4, 32'h78, 1); stepClock();

        applyStimulus(0, 5'd12, 5'd12, 0, 5'd0, 1, 5'd12, 32'h5, 1); stepClock();
        idle(5'd12, 5'd0);
        checkOutput("underflow_err", 32'(sb_err), 32'd1);
        stepClock();
        idle(5'd12, 5'd0); stepClock();
        idle(5'd12, 5'd0);
        checkOutput("underflow_sticky", 32'(sb_err), 32'd1);
        stepClock();
        applyStimulus(1, 5'd0, 5'd0, 0, 5'd0, 0, 5'd0, 32'd0, 0); stepClock();
        idle(5'd12, 5'd0);
        checkOutput("underflow_cleared", 32'(sb_err), 32'd0);
        stepClock();

        holdIss = 1'b0;
        iv = 1'b0;
        ia = 5'd0;
        for (int n = 0; n < 1500; n++) begin
            if (!holdIss) begin
                iv = 1'($urandom_range(0, 1));
                ia = 5'($urandom_range(0, 15));
            end
            applyStimulus(($urandom_range(0, 199) == 0),
                          5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                          iv, ia,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
                          ($urandom_range(0, 2) == 0));
            holdIss = iv && !mReady && !rst;
            stepClock();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file for the MIPS core, with a per-register pending-write scoreboard. Provides NUM_RD combinational read ports with same-cycle write-back bypass and one write-back port. Tracks outstanding producers (loads, mul/div) through an issue handshake and reports per-port hazard stalls to the decode stage. Register 0 reads as zero and is never written or tracked.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register index width; the file holds 2**ADDR_W registers
NUM_RD, 2, number of read ports
CNT_W, 2, width of each pending counter; at most 2**CNT_W-1 outstanding producers per register

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rd_addr  in  NUM_RD*ADDR_W  read indices; port i uses bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, flattened the same way
rd_stall  out  NUM_RD  port i's register has an unresolved producer
iss_valid  in  1  decode issues an instruction with a pending destination
iss_addr  in  ADDR_W  destination of the issued instruction
iss_ready  out  1  the issue can be accepted
wb_en  in  1  write-back strobe
wb_addr  in  ADDR_W  write-back index
wb_data  in  DATA_W  write-back data
wb_clr  in  1  this write-back retires a scoreboarded producer
sb_err  out  1  sticky: a retire was seen against a zero counter

Behaviour:
- State: regs[0..2**ADDR_W-1] (DATA_W) and cnt[0..2**ADDR_W-1] (CNT_W).
- Reset (rst=1 at posedge):
  - all regs and all cnt clear to 0; sb_err clears to 0.
  - Reset overrides any wb or issue in the same cycle.
  - Reset mid-operation discards all outstanding producers.
- Write, at posedge: if wb_en and wb_addr!=0, then regs[wb_addr] <= wb_data. Writes to index 0 are dropped.
- Read, combinational, zero latency, for each port i:
  - addr==0 -> rd_data = 0.
  - else if wb_en and wb_addr==addr -> rd_data = wb_data (bypass).
  - else -> regs[addr].
  - Read outputs do not depend on rst.
- Issue handshake:
  - iss_ready = (iss_addr==0) or (cnt[iss_addr] != all-ones).
  - The handshake fires when iss_valid and iss_ready. It increments cnt[iss_addr] at posedge, except when iss_addr==0 (no tracking).
  - iss_ready is combinational. When iss_valid is high and iss_ready is low, decode holds iss_valid and iss_addr stable.
- Retire: when wb_en and wb_clr and wb_addr!=0, cnt[wb_addr] decrements at posedge.
  - wb_en=1 with wb_clr=0 is a plain write with no counter change.
- Issue and retire on the same register in the same cycle: counter unchanged. Issue and retire on different registers: each is applied independently.
- Underflow: a retire while cnt==0 leaves the counter at 0 and sets sb_err=1 next cycle. sb_err stays set until reset.
- Stall, combinational: rd_stall[i] = (addr!=0) and (cnt[addr] > 0) and not bypass_resolves.
  - bypass_resolves = wb_en and wb_clr and wb_addr==addr and cnt[addr]==1. In that case the final producer's data is delivered this cycle.
- Counter saturation at all-ones: no increment is possible, because iss_ready is low.
- Duplicate read addresses across ports give identical data and stall values.

Decomposition:
- Shared package (cpu_pkg): DATA_W, ADDR_W defaults, REG_ZERO index constant, and a reg_idx_t typedef.
- Sub-module regfile_sb_cnt: one pending counter with inc, dec, zero, full and underflow outputs, instantiated 2**ADDR_W-1 times by a generate loop. Index 0 has no counter.
- The read mux and bypass logic are a generate loop over NUM_RD inside the top module.

Test Plan:
- Reset and zero register:
  - Assert rst for 2 cycles with wb_en=1, wb_addr=3, wb_data=0xDEADBEEF.
  - After reset, reading reg 3 returns 0 and sb_err=0.
  - A write of 0x1234 to reg 0 -> reading reg 0 returns 0.
- Bypass:
  - wb_en=1, wb_addr=7, wb_data=0xA5A5A5A5, with port0 and port1 both reading reg 7 in the same cycle.
  - Both ports return 0xA5A5A5A5 that cycle and the next cycle.
- Scoreboard stall:
  - Issue to reg 5, then read reg 5 -> rd_stall=1.
  - In the cycle with wb_en=1, wb_clr=1, wb_addr=5, wb_data=0x42: rd_stall=0 and rd_data=0x42.
  - Next cycle: stall=0, data=0x42.
- Saturation (CNT_W=2):
  - Issue to reg 9 three times -> iss_ready=0 on the 4th attempt while iss_valid is held.
  - One retire -> iss_ready=1 the following cycle.
  - rd_stall stays 1 until the 3rd retire.
- Same-cycle issue and retire on reg 4 with cnt=1:
  - Counter stays 1 and rd_stall stays 1.
  - Data is written with the wb_data value.
- Underflow: a retire to reg 12 with cnt=0 -> sb_err=1 next cycle, stays 1, and clears only on rst.
